// File: rtl/vga_scaled_fb_gen.sv
// vga_scaled_fb_gen
// VGA timing generator that integer-scales a double-buffered SRC_W x SRC_H
// framebuffer onto a configurable visible window.
//
// Stage 0 holds the raster counters and drives the synchronous read port.
// Stage 1 is the memory access. Stage 2 registers the colour. The sync and
// blank flags travel through two matching registers so that every video
// output describes the same raster position.
//
// The scaling uses sub-counters instead of dividers. src_x and src_y
// saturate one past the last source column and row. A set top bit then marks
// the pillarbox or letterbox area. That area is visible but reads nothing and
// shows colour 0.
//
// Buffer swaps can be requested at any time. A request is held pending and
// is applied only on the h=0, v=0 cycle, so one frame is always scanned from
// one buffer.
module vga_scaled_fb_gen #(
    parameter int H_SYNC           = 4,
    parameter int H_BACK           = 22,
    parameter int H_VISIBLE        = 128,
    parameter int H_FRONT          = 11,
    parameter int V_SYNC           = 5,
    parameter int V_BACK           = 100,
    parameter int V_VISIBLE        = 640,
    parameter int V_FRONT          = 45,
    parameter int SRC_W            = 64,
    parameter int SRC_H            = 32,
    parameter int SCALE_X          = 2,
    parameter int SCALE_Y          = 20,
    parameter int PIX_BITS         = 1,
    parameter int SYNC_ACTIVE_HIGH = 0
) (
    input  logic                                 pixel_clk_7_425mhz,
    input  logic                                 rst,
    input  logic                                 swap_req,
    input  logic [PIX_BITS-1:0]                  rd_data,
    output logic                                 rd_en,
    output logic [$clog2(SRC_H)+$clog2(SRC_W):0] rd_addr,
    output logic                                 buf_sel,
    output logic                                 swap_ack,
    output logic                                 frame_start,
    output logic [PIX_BITS-1:0]                  color,
    output logic                                 hsync,
    output logic                                 vsync,
    output logic                                 in_hblank,
    output logic                                 in_vblank
);

    // Raster geometry
    localparam int H_TOTAL = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;

    // Counter widths. The +1 lets the window end compare against H_TOTAL.
    localparam int HW  = $clog2(H_TOTAL + 1);
    localparam int VW  = $clog2(V_TOTAL + 1);
    localparam int XW  = $clog2(SRC_W);
    localparam int YW  = $clog2(SRC_H);
    localparam int SXW = (SCALE_X > 1) ? $clog2(SCALE_X) : 1;
    localparam int SYW = (SCALE_Y > 1) ? $clog2(SCALE_Y) : 1;

    // Sized compare constants
    localparam logic [HW-1:0]  H_LAST      = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0]  V_LAST      = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0]  H_SYNC_END  = HW'(H_SYNC);
    localparam logic [VW-1:0]  V_SYNC_END  = VW'(V_SYNC);
    localparam logic [HW-1:0]  H_VIS_START = HW'(H_SYNC + H_BACK);
    localparam logic [HW-1:0]  H_VIS_END   = HW'(H_SYNC + H_BACK + H_VISIBLE);
    localparam logic [VW-1:0]  V_VIS_START = VW'(V_SYNC + V_BACK);
    localparam logic [VW-1:0]  V_VIS_END   = VW'(V_SYNC + V_BACK + V_VISIBLE);
    localparam logic [SXW-1:0] SX_LAST     = SXW'(SCALE_X - 1);
    localparam logic [SYW-1:0] SY_LAST     = SYW'(SCALE_Y - 1);
    localparam logic [XW:0]    SRC_X_SAT   = (XW + 1)'(SRC_W);
    localparam logic [YW:0]    SRC_Y_SAT   = (YW + 1)'(SRC_H);

    // Sync levels
    localparam logic SYNC_ON  = (SYNC_ACTIVE_HIGH != 0);
    localparam logic SYNC_OFF = ~SYNC_ON;

    // Elaboration-time parameter sanity
    if (H_VISIBLE < SCALE_X || SCALE_X < 1) begin : g_bad_scale_x
        $error("vga_scaled_fb_gen: need 1 <= SCALE_X <= H_VISIBLE");
    end
    if (V_VISIBLE < SCALE_Y || SCALE_Y < 1) begin : g_bad_scale_y
        $error("vga_scaled_fb_gen: need 1 <= SCALE_Y <= V_VISIBLE");
    end
    if (SRC_W < 2 || (SRC_W & (SRC_W - 1)) != 0) begin : g_bad_src_w
        $error("vga_scaled_fb_gen: SRC_W must be a power of 2");
    end
    if (SRC_H < 2 || (SRC_H & (SRC_H - 1)) != 0) begin : g_bad_src_h
        $error("vga_scaled_fb_gen: SRC_H must be a power of 2");
    end
    if (H_SYNC + H_BACK + H_FRONT < 1) begin : g_no_hblank
        $error("vga_scaled_fb_gen: line needs at least one blank pixel");
    end

    // Side-band video flags that travel with each raster position
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic hblank;
        logic vblank;
        logic fstart;
    } side_t;

    localparam side_t SIDE_RESET = '{
        hsync:  SYNC_OFF,
        vsync:  SYNC_OFF,
        hblank: 1'b1,
        vblank: 1'b1,
        fstart: 1'b0
    };

    // Stage-0 state
    logic [HW-1:0]  h;
    logic [VW-1:0]  v;
    logic [SXW-1:0] sx;
    logic [SYW-1:0] sy;
    logic [XW:0]    src_x;
    logic [YW:0]    src_y;
    logic           pending;

    // Stage-0 decode
    logic  h_vis;
    logic  v_vis;
    logic  line_end;
    logic  frame_end;
    logic  frame_first;
    logic  active;
    logic  do_swap;
    side_t side_s0;

    // Pipeline registers
    logic  active_d1;
    side_t side_d1;
    side_t side_d2;

    // Decode the current raster position and the buffer-swap condition
    // NOTE: every signal gets a default first, so no path through this block can infer a latch.
    always_comb begin
        h_vis          = (h >= H_VIS_START) && (h < H_VIS_END);
        v_vis          = (v >= V_VIS_START) && (v < V_VIS_END);
        line_end       = (h == H_LAST);
        frame_end      = line_end && (v == V_LAST);
        frame_first    = (h == '0) && (v == '0);
        // A saturated source coordinate has its top bit set. That marks a border.
        active         = h_vis && v_vis && !src_x[XW] && !src_y[YW];
        do_swap        = frame_first && (pending || swap_req);

        side_s0        = SIDE_RESET;
        side_s0.hsync  = (h < H_SYNC_END) ? SYNC_ON : SYNC_OFF;
        side_s0.vsync  = (v < V_SYNC_END) ? SYNC_ON : SYNC_OFF;
        side_s0.hblank = !h_vis;
        side_s0.vblank = !v_vis;
        side_s0.fstart = frame_first;
    end

    // Drive the memory read port and the swap acknowledge from stage-0 state
    always_comb begin
        rd_en    = active;
        rd_addr  = {buf_sel, src_y[YW-1:0], src_x[XW-1:0]};
        // Gate with reset: the counters sit at h=0, v=0 throughout reset.
        swap_ack = do_swap && !rst;
    end

    // Advance the horizontal and vertical raster counters
    // NOTE: non-blocking assignments make every register sample pre-edge values, whatever the statement order.
    always_ff @(posedge pixel_clk_7_425mhz or posedge rst) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else if (line_end) begin
            h <= '0;
            v <= frame_end ? '0 : v + 1'b1;
        end else begin
            h <= h + 1'b1;
        end
    end

    // Horizontal scaler. It is held clear outside the visible window, so each line starts at 0.
    always_ff @(posedge pixel_clk_7_425mhz or posedge rst) begin
        if (rst) begin
            sx    <= '0;
            src_x <= '0;
        end else if (!h_vis) begin
            sx    <= '0;
            src_x <= '0;
        end else if (sx == SX_LAST) begin
            sx <= '0;
            if (src_x != SRC_X_SAT) begin
                src_x <= src_x + 1'b1;
            end
        end else begin
            sx <= sx + 1'b1;
        end
    end

    // Vertical scaler. It steps once per visible line and clears when the frame wraps to v=0.
    always_ff @(posedge pixel_clk_7_425mhz or posedge rst) begin
        if (rst) begin
            sy    <= '0;
            src_y <= '0;
        end else if (line_end) begin
            if (frame_end) begin
                sy    <= '0;
                src_y <= '0;
            end else if (v_vis) begin
                if (sy == SY_LAST) begin
                    sy <= '0;
                    if (src_y != SRC_Y_SAT) begin
                        src_y <= src_y + 1'b1;
                    end
                end else begin
                    sy <= sy + 1'b1;
                end
            end
        end
    end

    // Hold swap requests pending and toggle the scanned buffer only at frame start
    always_ff @(posedge pixel_clk_7_425mhz or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
            buf_sel <= 1'b0;
        end else if (do_swap) begin
            pending <= 1'b0;
            buf_sel <= ~buf_sel;
        end else if (swap_req) begin
            pending <= 1'b1;
        end
    end

    // Stage 1: carry the active flag and the side-band flags alongside the memory access
    always_ff @(posedge pixel_clk_7_425mhz or posedge rst) begin
        if (rst) begin
            active_d1 <= 1'b0;
            side_d1   <= SIDE_RESET;
        end else begin
            active_d1 <= active;
            side_d1   <= side_s0;
        end
    end

    // Stage 2: register the colour and the aligned side-band flags
    always_ff @(posedge pixel_clk_7_425mhz or posedge rst) begin
        if (rst) begin
            color   <= '0;
            side_d2 <= SIDE_RESET;
        end else begin
            color   <= active_d1 ? rd_data : '0;
            side_d2 <= side_d1;
        end
    end

    // Map the aligned side-band flags onto the video outputs
    always_comb begin
        hsync       = side_d2.hsync;
        vsync       = side_d2.vsync;
        in_hblank   = side_d2.hblank;
        in_vblank   = side_d2.vblank;
        frame_start = side_d2.fstart;
    end

endmodule

// File: tb/tb_vga_scaled_fb_gen.sv
// tb_vga_scaled_fb_gen
// Three instances share one clock:
//   a: default geometry, active-low syncs, memory returns addr[0]
//   b: small geometry with pillarbox and letterbox, active-high syncs,
//      2-bit pixels and random memory contents, so many frames fit in the run
//   c: default geometry with active-high syncs
// A behavioural model derives every output from the elapsed cycle count.
// It uses plain modulo and division arithmetic. The model is checked on
// every cycle, and a set of hand-computed literals pins the model itself.
module tb_vga_scaled_fb_gen;

    localparam int N_CYC = 20700;

    typedef struct {
        int hs, hb, hv, hf, vs, vb, vv, vf;
        int sw, sh, scx, scy, pol, xw, yw;
    } cfg_t;

    cfg_t cfg [3];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int g;
    int checks = 0;
    int errors = 0;

    // ---------------- instance a ----------------
    logic        rst_a, swap_a, rd_en_a, buf_sel_a, swap_ack_a, fs_a;
    logic        hsync_a, vsync_a, hbl_a, vbl_a;
    logic [0:0]  rd_data_a, color_a;
    logic [11:0] rd_addr_a;

    vga_scaled_fb_gen dut_a (
        .pixel_clk_7_425mhz(clk), .rst(rst_a), .swap_req(swap_a),
        .rd_data(rd_data_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a),
        .buf_sel(buf_sel_a), .swap_ack(swap_ack_a), .frame_start(fs_a),
        .color(color_a), .hsync(hsync_a), .vsync(vsync_a),
        .in_hblank(hbl_a), .in_vblank(vbl_a)
    );

    // ---------------- instance b ----------------
    logic        rst_b, swap_b, rd_en_b, buf_sel_b, swap_ack_b, fs_b;
    logic        hsync_b, vsync_b, hbl_b, vbl_b;
    logic [1:0]  rd_data_b, color_b;
    logic [5:0]  rd_addr_b;
    logic [1:0]  mem_b [64];

    vga_scaled_fb_gen #(
        .H_SYNC(2), .H_BACK(3), .H_VISIBLE(20), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(2), .V_VISIBLE(14), .V_FRONT(2),
        .SRC_W(8), .SRC_H(4), .SCALE_X(2), .SCALE_Y(3),
        .PIX_BITS(2), .SYNC_ACTIVE_HIGH(1)
    ) dut_b (
        .pixel_clk_7_425mhz(clk), .rst(rst_b), .swap_req(swap_b),
        .rd_data(rd_data_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
        .buf_sel(buf_sel_b), .swap_ack(swap_ack_b), .frame_start(fs_b),
        .color(color_b), .hsync(hsync_b), .vsync(vsync_b),
        .in_hblank(hbl_b), .in_vblank(vbl_b)
    );

    // ---------------- instance c ----------------
    logic        rst_c, swap_c, rd_en_c, buf_sel_c, swap_ack_c, fs_c;
    logic        hsync_c, vsync_c, hbl_c, vbl_c;
    logic [0:0]  rd_data_c, color_c;
    logic [11:0] rd_addr_c;

    vga_scaled_fb_gen #(.SYNC_ACTIVE_HIGH(1)) dut_c (
        .pixel_clk_7_425mhz(clk), .rst(rst_c), .swap_req(swap_c),
        .rd_data(rd_data_c), .rd_en(rd_en_c), .rd_addr(rd_addr_c),
        .buf_sel(buf_sel_c), .swap_ack(swap_ack_c), .frame_start(fs_c),
        .color(color_c), .hsync(hsync_c), .vsync(vsync_c),
        .in_hblank(hbl_c), .in_vblank(vbl_c)
    );

    // Synchronous 1-cycle-latency memories
    always @(posedge clk) begin
        if (rd_en_a) rd_data_a <= rd_addr_a[0];
        if (rd_en_b) rd_data_b <= mem_b[rd_addr_b];
        if (rd_en_c) rd_data_c <= rd_addr_c[0];
    end

    // ---------------- behavioural model ----------------
    int mc      [3];   // cycles since reset release
    bit mpend   [3];
    bit mbsel   [3];
    int col_s1  [3];
    int col_out [3];
    bit rst_v   [3];
    bit req_v   [3];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, g, act, exp);
        end
    endtask

    function automatic int frame_len(input cfg_t k);
        return (k.hs + k.hb + k.hv + k.hf) * (k.vs + k.vb + k.vv + k.vf);
    endfunction

    // Everything about raster position t, computed with plain arithmetic
    function automatic void timing(input cfg_t k, input int t,
                                   output bit hs, output bit vs, output bit hbl, output bit vbl,
                                   output bit fs, output bit act, output int ex, output int ey);
        int ht, vt, h, v, hvs, vvs;
        bit hvis, vvis;
        ht   = k.hs + k.hb + k.hv + k.hf;
        vt   = k.vs + k.vb + k.vv + k.vf;
        h    = t % ht;
        v    = (t / ht) % vt;
        hvs  = k.hs + k.hb;
        vvs  = k.vs + k.vb;
        hvis = (h >= hvs) && (h < hvs + k.hv);
        vvis = (v >= vvs) && (v < vvs + k.vv);
        hs   = (h < k.hs) ? (k.pol != 0) : (k.pol == 0);
        vs   = (v < k.vs) ? (k.pol != 0) : (k.pol == 0);
        hbl  = !hvis;
        vbl  = !vvis;
        fs   = (h == 0) && (v == 0);
        ex   = (h - hvs) / k.scx;
        ey   = (v - vvs) / k.scy;
        act  = hvis && vvis && (ex < k.sw) && (ey < k.sh);
    endfunction

    function automatic int mk_addr(input cfg_t k, input bit bsel, input int ex, input int ey);
        return (int'(bsel) << (k.xw + k.yw)) | (ey << k.xw) | ex;
    endfunction

    function automatic int mem_read(input int id, input int addr);
        if (id == 1) return int'(mem_b[addr[5:0]]);
        return addr & 1;
    endfunction

    task automatic model_reset(input int id);
        mc[id]      = 0;
        mpend[id]   = 1'b0;
        mbsel[id]   = 1'b0;
        col_s1[id]  = 0;
        col_out[id] = 0;
    endtask

    task automatic model_edge(input int id);
        bit hs, vs, hbl, vbl, fs, act, f0;
        int ex, ey;
        if (rst_v[id]) begin
            model_reset(id);
        end else begin
            timing(cfg[id], mc[id], hs, vs, hbl, vbl, fs, act, ex, ey);
            f0          = (mc[id] % frame_len(cfg[id])) == 0;
            col_out[id] = col_s1[id];
            col_s1[id]  = act ? mem_read(id, mk_addr(cfg[id], mbsel[id], ex, ey)) : 0;
            if (f0 && (mpend[id] || req_v[id])) begin
                mbsel[id] = ~mbsel[id];
                mpend[id] = 1'b0;
            end else if (req_v[id]) begin
                mpend[id] = 1'b1;
            end
            mc[id]++;
        end
    endtask

    task automatic check_outputs(input int id, input string p,
                                 input logic rd_en, input int rd_addr, input logic buf_sel,
                                 input logic swap_ack, input logic fs, input int color,
                                 input logic hs, input logic vs, input logic hbl, input logic vbl);
        bit e_hs, e_vs, e_hbl, e_vbl, e_fs, e_act, f0;
        int ex, ey;
        // Stage-0 outputs reflect the current raster position
        timing(cfg[id], mc[id], e_hs, e_vs, e_hbl, e_vbl, e_fs, e_act, ex, ey);
        f0 = (mc[id] % frame_len(cfg[id])) == 0;
        check({p, "_rd_en"}, rd_en, !rst_v[id] && e_act);
        if (!rst_v[id] && e_act)
            check({p, "_rd_addr"}, rd_addr, mk_addr(cfg[id], mbsel[id], ex, ey));
        check({p, "_buf_sel"}, buf_sel, mbsel[id]);
        check({p, "_swap_ack"}, swap_ack, !rst_v[id] && f0 && (mpend[id] || req_v[id]));
        // Video outputs describe the raster position two cycles back
        if (mc[id] >= 2) begin
            timing(cfg[id], mc[id] - 2, e_hs, e_vs, e_hbl, e_vbl, e_fs, e_act, ex, ey);
        end else begin
            e_hs  = (cfg[id].pol == 0);
            e_vs  = (cfg[id].pol == 0);
            e_hbl = 1'b1;
            e_vbl = 1'b1;
            e_fs  = 1'b0;
        end
        check({p, "_hsync"}, hs, e_hs);
        check({p, "_vsync"}, vs, e_vs);
        check({p, "_in_hblank"}, hbl, e_hbl);
        check({p, "_in_vblank"}, vbl, e_vbl);
        check({p, "_frame_start"}, fs, e_fs);
        check({p, "_color"}, color, col_out[id]);
    endtask

    // ---------------- stimulus and compare ----------------
    int  rb_left = 0;
    int  hs_fall_a [2];
    int  n_hs_fall_a = 0;
    int  vs_rise_a = -1;
    int  first_rd_a = -1;
    int  fs_cnt_a = 0;
    int  fs_cnt_b = 0;
    int  ack_cnt_b = 0;
    bit  prev_hs_a = 1'b1;
    bit  prev_vs_a = 1'b1;

    initial begin
        cfg[0] = '{4, 22, 128, 11, 5, 100, 640, 45, 64, 32, 2, 20, 0, 6, 5};
        cfg[1] = '{2, 3, 20, 2, 2, 2, 14, 2, 8, 4, 2, 3, 1, 3, 2};
        cfg[2] = '{4, 22, 128, 11, 5, 100, 640, 45, 64, 32, 2, 20, 1, 6, 5};
        for (int i = 0; i < 64; i++) mem_b[i] = 2'($urandom_range(0, 3));
        for (int i = 0; i < 3; i++) model_reset(i);
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        swap_a = 1'b0; swap_b = 1'b0; swap_c = 1'b0;

        for (g = -3; g < N_CYC; g++) begin
            @(negedge clk);
            // Drive this cycle's inputs
            rst_a  = (g < 0);
            rst_c  = (g < 0);
            swap_a = 1'b0;
            swap_c = (g == 0) || (g > 0 && $urandom_range(0, 999) == 0);
            if (rb_left > 0) begin
                rst_b = 1'b1;
                rb_left--;
            end else if (g >= 2000 && $urandom_range(0, 2999) == 0) begin
                rst_b   = 1'b1;
                rb_left = $urandom_range(0, 2);
            end else begin
                rst_b = (g < 0) || (g >= 1800 && g < 1804);
            end
            swap_b = (g == 100) || (g == 600) || (g == 700) || (g == 800) || (g == 1620) ||
                     (g >= 2000 && $urandom_range(0, 149) == 0);
            rst_v[0] = rst_a; rst_v[1] = rst_b; rst_v[2] = rst_c;
            req_v[0] = swap_a; req_v[1] = swap_b; req_v[2] = swap_c;
            for (int i = 0; i < 3; i++) if (rst_v[i]) model_reset(i);
            #1;

            check_outputs(0, "a", rd_en_a, int'(rd_addr_a), buf_sel_a, swap_ack_a, fs_a,
                          int'(color_a), hsync_a, vsync_a, hbl_a, vbl_a);
            check_outputs(1, "b", rd_en_b, int'(rd_addr_b), buf_sel_b, swap_ack_b, fs_b,
                          int'(color_b), hsync_b, vsync_b, hbl_b, vbl_b);
            check_outputs(2, "c", rd_en_c, int'(rd_addr_c), buf_sel_c, swap_ack_c, fs_c,
                          int'(color_c), hsync_c, vsync_c, hbl_c, vbl_c);

            // Event bookkeeping for the hand-computed expectations
            if (g >= 0) begin
                if (prev_hs_a && !hsync_a && n_hs_fall_a < 2) begin
                    hs_fall_a[n_hs_fall_a] = g;
                    n_hs_fall_a++;
                end
                if (!prev_vs_a && vsync_a && vs_rise_a < 0) vs_rise_a = g;
                if (rd_en_a && first_rd_a < 0) first_rd_a = g;
                if (fs_a) fs_cnt_a++;
                if (g < 1700 && fs_b) fs_cnt_b++;
                if (g < 1700 && swap_ack_b) ack_cnt_b++;
                prev_hs_a = hsync_a;
                prev_vs_a = vsync_a;
            end

            // Hand-computed literal expectations
            if (g == 3)     check("c_hsync_active_high", hsync_c, 1);
            if (g == 6)     check("c_hsync_idle_low", hsync_c, 0);
            if (g == 128)   check("b_last_active_px", rd_en_b, 1);
            if (g == 129)   check("b_pillar_rd_en", rd_en_b, 0);
            if (g == 131) begin
                check("b_pillar_hblank", hbl_b, 0);
                check("b_pillar_color", color_b, 0);
            end
            if (g == 540)   check("b_swap_ack_frame1", swap_ack_b, 1);
            if (g == 1620)  check("b_swap_ack_same_cycle", swap_ack_b, 1);
            if (g == 1700)  check("b_buf_sel_after_3_swaps", buf_sel_b, 1);
            if (g == 1800) begin
                check("b_reset_buf_sel", buf_sel_b, 0);
                check("b_reset_vblank", vbl_b, 1);
                check("b_reset_hsync", hsync_b, 0);
            end
            if (g == 17351) begin
                check("a_first_rd_en", rd_en_a, 1);
                check("a_first_rd_addr", rd_addr_a, 0);
            end
            if (g == 17353) check("a_color_h28", color_a, 0);
            if (g == 17355) check("a_color_h30", color_a, 1);
            if (g == 17357) check("a_color_h32", color_a, 0);
            if (g == 20486) check("a_rd_addr_row0_last_line", rd_addr_a, 0);
            if (g == 20651) begin
                check("a_rd_en_row1", rd_en_a, 1);
                check("a_rd_addr_row1", rd_addr_a, 64);
            end

            @(posedge clk);
            for (int i = 0; i < 3; i++) model_edge(i);
        end

        check("a_hsync_first_fall", hs_fall_a[0], 2);
        check("a_hsync_second_fall", hs_fall_a[1], 167);
        check("a_vsync_first_rise", vs_rise_a, 827);
        check("a_first_rd_cycle", first_rd_a, 17351);
        check("a_frame_start_count", fs_cnt_a, 1);
        check("b_frame_start_count", fs_cnt_b, 4);
        check("b_swap_ack_count", ack_cnt_b, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
